// File: rtl/perf_cnt_unit.sv
// perf_cnt_unit: generic event-selectable performance counters for the RV64 core.
// Optional shadow snapshot registers enabled by defining PERF_CNT_SHADOW_EN.
module perf_cnt_unit #(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 16,
  parameter int EVT_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_EVT-1:0]   evt_i,
  input  logic                 global_en,
  input  logic                 freeze,
  input  logic                 snap,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [4:0]           wr_idx,
  input  logic [CNT_WIDTH-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 rd_sel,
  input  logic [4:0]           rd_idx,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic [NUM_CNT-1:0]   ovf,
  output logic                 irq
);

  logic [CNT_WIDTH-1:0] cnt     [NUM_CNT];
  logic [EVT_SEL_W-1:0] evt_sel [NUM_CNT];

  logic [NUM_CNT-1:0] en;
  logic [NUM_CNT-1:0] irq_en;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] wr_cnt;
  logic [NUM_CNT-1:0] wr_ctl;
  logic [NUM_CNT-1:0] wrap;
  logic               ovf_clr;
  logic               cnt_gate;

  logic [CNT_WIDTH-1:0] rd_val;

`ifdef PERF_CNT_SHADOW_EN
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
`else
  logic snap_unused;
  assign snap_unused = snap;
`endif

  assign ovf_clr  = wr_data[EVT_SEL_W+2];
  assign cnt_gate = global_en & ~freeze;

  // A value write wins over a same-cycle increment, so it also masks the wrap.
  always_comb begin
    inc    = '0;
    wr_cnt = '0;
    wr_ctl = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      inc[i]    = en[i] & cnt_gate
                & evt_i[evt_sel[i]];
      wr_cnt[i] = wr_en & ~wr_sel
                & (wr_idx == 5'(i));
      wr_ctl[i] = wr_en & wr_sel
                & (wr_idx == 5'(i));
      wrap[i]   = inc[i] & ~wr_cnt[i]
                & (&cnt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]     <= '0;
        evt_sel[i] <= '0;
      end
      en     <= '0;
      irq_en <= '0;
      ovf    <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_cnt[i]) begin
          cnt[i] <= wr_data;
        end else if (inc[i]) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
        if (wr_ctl[i]) begin
          evt_sel[i] <= wr_data[EVT_SEL_W-1:0];
          en[i]      <= wr_data[EVT_SEL_W];
          irq_en[i]  <= wr_data[EVT_SEL_W+1];
        end
        if (wrap[i]) begin
          ovf[i] <= 1'b1;
        end else if (wr_ctl[i] && ovf_clr) begin
          ovf[i] <= 1'b0;
        end
      end
    end
  end

`ifdef PERF_CNT_SHADOW_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_cnt[i]) begin
          shadow[i] <= wr_data;
        end else if (snap) begin
          shadow[i] <= cnt[i];
        end
      end
    end
  end
`endif

  // Out-of-range indices match no counter and fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == 5'(i)) begin
        if (rd_sel) begin
          rd_val = CNT_WIDTH'({ovf[i],
                               irq_en[i],
                               en[i],
                               evt_sel[i]});
        end else begin
`ifdef PERF_CNT_SHADOW_EN
          rd_val = shadow[i];
`else
          rd_val = cnt[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_val;
      end
      irq <= |(ovf & irq_en);
    end
  end

endmodule

// File: tb/tb_perf_cnt_unit.sv
// tb_perf_cnt_unit: directed vectors and corner sequences for perf_cnt_unit.
// A second 8-bit-wide instance shares the stimulus for wrap/interrupt cases.
module tb_perf_cnt_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] evt_i = '0;
  logic        global_en = 1'b0;
  logic        freeze = 1'b0;
  logic        snap = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [4:0]  wr_idx = '0;
  logic [63:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic        rd_sel = 1'b0;
  logic [4:0]  rd_idx = '0;

  logic [63:0] rd_data;
  logic        rd_valid;
  logic [7:0]  ovf;
  logic        irq;
  logic [7:0]  rd_data8;
  logic        rd_valid8;
  logic [7:0]  ovf8;
  logic        irq8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  perf_cnt_unit #(
    .NUM_CNT(8), .CNT_WIDTH(64),
    .NUM_EVT(16), .EVT_SEL_W(4)
  ) u_dut (
    .clk(clk), .rst(rst), .evt_i(evt_i),
    .global_en(global_en), .freeze(freeze),
    .snap(snap), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_idx(wr_idx),
    .wr_data(wr_data), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .ovf(ovf), .irq(irq)
  );

  perf_cnt_unit #(
    .NUM_CNT(8), .CNT_WIDTH(8),
    .NUM_EVT(16), .EVT_SEL_W(4)
  ) u_dut8 (
    .clk(clk), .rst(rst), .evt_i(evt_i),
    .global_en(global_en), .freeze(freeze),
    .snap(snap), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_idx(wr_idx),
    .wr_data(wr_data[7:0]), .rd_en(rd_en),
    .rd_sel(rd_sel), .rd_idx(rd_idx),
    .rd_data(rd_data8), .rd_valid(rd_valid8),
    .ovf(ovf8), .irq(irq8)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] ctl;
    logic [63:0] init;
    logic [15:0] evt;
    int          n;
    logic        ge;
    logic        frz;
    logic [63:0] exp;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic s,
                    input logic [4:0] i,
                    input logic [63:0] d);
    wr_en = 1'b1;
    wr_sel = s;
    wr_idx = i;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_raw(input logic s,
                        input logic [4:0] i);
    rd_en = 1'b1;
    rd_sel = s;
    rd_idx = i;
    tick();
    rd_en = 1'b0;
    chk("rd_valid", 64'(rd_valid), 64'd1);
  endtask

  task automatic rd(input logic s,
                    input logic [4:0] i);
`ifdef PERF_CNT_SHADOW_EN
    if (!s) begin
      snap = 1'b1;
      tick();
      snap = 1'b0;
    end
`endif
    rd_raw(s, i);
  endtask

  task automatic pulse(input logic [15:0] m,
                       input int n);
    for (int k = 0; k < n; k++) begin
      evt_i = m;
      tick();
    end
    evt_i = '0;
  endtask

  initial begin
    v[0] = '{5'd1, 64'h13, 64'd0, 16'h0008,
             10, 1'b1, 1'b0, 64'd10};
    v[1] = '{5'd1, 64'h13, 64'd0, 16'h0004,
             7, 1'b1, 1'b0, 64'd0};
    v[2] = '{5'd3, 64'h15, 64'd100, 16'h0022,
             4, 1'b1, 1'b0, 64'd104};
    v[3] = '{5'd4, 64'h17, 64'd0, 16'h0080,
             4, 1'b1, 1'b1, 64'd0};
    v[4] = '{5'd4, 64'h17, 64'd0, 16'h0080,
             4, 1'b0, 1'b0, 64'd0};
    v[5] = '{5'd5, 64'h05, 64'd0, 16'h0020,
             3, 1'b1, 1'b0, 64'd0};
    v[6] = '{5'd6, 64'h1F,
             64'hFFFF_FFFF_FFFF_FFFE, 16'h8000,
             2, 1'b1, 1'b0, 64'd0};
    v[7] = '{5'd7, 64'h15, 64'd0, 16'h0020,
             3, 1'b1, 1'b0, 64'd3};

    // reset state
    #1;
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    tick();
    tick();
    rst = 1'b1;

    // reset in the middle of counting
    wr(1'b1, 5'd0, 64'h10);
    global_en = 1'b1;
    pulse(16'h0001, 5);
    rd(1'b0, 5'd0);
    chk("cnt0_pre_rst", rd_data, 64'd5);
    evt_i = 16'h0001;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_rd_data", rd_data, 64'd0);
    chk("arst_rd_valid", 64'(rd_valid), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_irq", 64'(irq), 64'd0);
    evt_i = '0;
    tick();
    rst = 1'b1;
    rd(1'b0, 5'd0);
    chk("cnt0_post_rst", rd_data, 64'd0);
    rd(1'b1, 5'd0);
    chk("ctl0_post_rst", rd_data, 64'd0);
    tick();
    chk("rd_valid_idle", 64'(rd_valid), 64'd0);

    // table-driven count vectors
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, v[i].idx, v[i].init);
      wr(1'b1, v[i].idx, v[i].ctl);
      global_en = v[i].ge;
      freeze = v[i].frz;
      pulse(v[i].evt, v[i].n);
      global_en = 1'b1;
      freeze = 1'b0;
      rd(1'b0, v[i].idx);
      chk($sformatf("vec%0d", i), rd_data, v[i].exp);
    end

    // cnt3 and cnt7 both follow event 5
    rd(1'b0, 5'd3);
    chk("cnt3_shared_evt", rd_data, 64'd110);
    rd(1'b1, 5'd1);
    chk("ctl1_read", rd_data, 64'h13);
    rd(1'b1, 5'd6);
    chk("ctl6_ovf_bit", rd_data, 64'h5F);
    chk("ovf64_after_vec", 64'(ovf), 64'h40);
    chk("irq64_masked", 64'(irq), 64'd0);
    chk("ovf8_after_vec", 64'(ovf8), 64'h40);

    // wrap and interrupt on the 8-bit instance
    wr(1'b0, 5'd2, 64'hFE);
    wr(1'b1, 5'd2, 64'h30);
    pulse(16'h0001, 1);
    chk("wrap_pre_ovf", 64'(ovf8[2]), 64'd0);
    pulse(16'h0001, 1);
    chk("wrap_ovf", 64'(ovf8[2]), 64'd1);
    chk("wrap_irq_lag", 64'(irq8), 64'd0);
    tick();
    chk("wrap_irq", 64'(irq8), 64'd1);
    rd(1'b0, 5'd2);
    chk("wrap_cnt", 64'(rd_data8), 64'd0);
    wr(1'b1, 5'd2, 64'h70);
    chk("w1c_ovf", 64'(ovf8[2]), 64'd0);
    chk("w1c_irq_lag", 64'(irq8), 64'd1);
    tick();
    chk("w1c_irq", 64'(irq8), 64'd0);

    // value write beats same-cycle increment
    wr(1'b1, 5'd0, 64'h10);
    wr_en = 1'b1;
    wr_sel = 1'b0;
    wr_idx = 5'd0;
    wr_data = 64'h100;
    evt_i = 16'h0001;
    tick();
    wr_en = 1'b0;
    evt_i = '0;
    rd(1'b0, 5'd0);
    chk("wr_over_inc", rd_data, 64'h100);

    // overflow set beats same-cycle W1C
    wr(1'b0, 5'd2, 64'hFF);
    wr_en = 1'b1;
    wr_sel = 1'b1;
    wr_idx = 5'd2;
    wr_data = 64'h70;
    evt_i = 16'h0001;
    tick();
    wr_en = 1'b0;
    evt_i = '0;
    chk("set_over_w1c", 64'(ovf8[2]), 64'd1);
    wr(1'b0, 5'd2, 64'h05);
    chk("wr_keeps_ovf", 64'(ovf8[2]), 64'd1);

    // out-of-range index
    wr(1'b0, 5'd9, 64'hDEAD);
    wr(1'b1, 5'd9, 64'h1F);
    rd(1'b0, 5'd1);
    chk("oor_wr_cnt1", rd_data, 64'd0);
    rd(1'b1, 5'd1);
    chk("oor_wr_ctl1", rd_data, 64'h13);
    rd(1'b0, 5'd9);
    chk("oor_rd", rd_data, 64'd0);

    // read and write of one counter in one cycle
`ifdef PERF_CNT_SHADOW_EN
    snap = 1'b1;
    tick();
    snap = 1'b0;
`endif
    rd_en = 1'b1;
    rd_sel = 1'b0;
    rd_idx = 5'd7;
    wr_en = 1'b1;
    wr_sel = 1'b0;
    wr_idx = 5'd7;
    wr_data = 64'd50;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("rdwr_old", rd_data, 64'd3);
    rd(1'b0, 5'd7);
    chk("rdwr_new", rd_data, 64'd50);

`ifdef PERF_CNT_SHADOW_EN
    // coherent sampling through the shadow
    wr(1'b0, 5'd0, 64'd20);
    wr(1'b1, 5'd0, 64'h10);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    pulse(16'h0001, 5);
    rd_raw(1'b0, 5'd0);
    chk("shadow_hold", rd_data, 64'd20);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    rd_raw(1'b0, 5'd0);
    chk("shadow_snap", rd_data, 64'd25);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_cnt_unit.md
Name: perf_cnt_unit

Overview:
- Parametrised hardware performance-monitor block for the 5-stage RV64 core.
- Replaces fixed per-event counters (inst, mem, mul, div) with NUM_CNT generic counters. Each counter is software-configurable to count any one of NUM_EVT single-cycle event pulses.
- Sits beside the pipeline top. Stages drive evt_i; a CSR/debug side accesses counters through a registered read/write port.
- Adds global enable, freeze, sticky overflow and an overflow interrupt.

Parameters:
- NUM_CNT, 8, number of counters (1..32).
- CNT_WIDTH, 64, counter width in bits (8..64).
- NUM_EVT, 16, number of event inputs; must equal 2**EVT_SEL_W.
- EVT_SEL_W, 4, width of per-counter event-select field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- evt_i  in  NUM_EVT  event pulses; bit e high = one occurrence of event e this cycle.
- global_en  in  1  master count enable.
- freeze  in  1  suspends all counting while high (e.g. debug halt).
- snap  in  1  snapshot request pulse; used only with the optional feature.
- wr_en  in  1  write strobe.
- wr_sel  in  1  0 = counter value, 1 = control word.
- wr_idx  in  5  counter index.
- wr_data  in  CNT_WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_sel  in  1  0 = counter value, 1 = control/status word.
- rd_idx  in  5  counter index.
- rd_data  out  CNT_WIDTH  read data, registered.
- rd_valid  out  1  high one cycle after the accepted rd_en.
- ovf  out  NUM_CNT  sticky overflow flags.
- irq  out  1  registered overflow interrupt.

Behaviour:
- Reset (rst low, asynchronous): all counters, control words, ovf, rd_data, rd_valid and irq are 0. Release is synchronous to clk.
- Control word layout for counter i:
  - [EVT_SEL_W-1:0] = evt_sel
  - [EVT_SEL_W] = en
  - [EVT_SEL_W+1] = irq_en
  - [EVT_SEL_W+2] = ovf clear, write-1-to-clear, reads as the ovf[i] status bit
  - higher bits read 0
- Increment condition: en[i] && global_en && !freeze && evt_i[evt_sel[i]]. When met, cnt[i] <= cnt[i]+1 at the next edge. Increment is at most 1 per cycle.
- Wrap-around: increment at all-ones gives 0 and sets ovf[i] in the same edge. Arithmetic is modulo 2**CNT_WIDTH.
- Value write (wr_sel=0, wr_idx<NUM_CNT): cnt <= wr_data[CNT_WIDTH-1:0]. The write has priority over a same-cycle increment; that increment is lost. A write never sets or clears ovf.
- Control write (wr_sel=1): updates evt_sel, en and irq_en. If bit EVT_SEL_W+2 is set, ovf[i] clears. If a wrap sets ovf[i] in the same cycle, set wins and ovf stays 1.
- An evt_sel change takes effect from the next cycle. The increment in the write cycle uses the old select.
- Out-of-range index (idx >= NUM_CNT): writes are ignored; reads return 0 with rd_valid=1.
- Read latency is 1 cycle. rd_data captures pre-edge state, so a read and write to the same counter in the same cycle returns the old value.
- rd_valid=0 in cycles without a preceding rd_en. rd_data holds its last value.
- irq <= |(ovf & irq_en), registered, so it is 1 cycle after the ovf flag updates. irq drops the cycle after the flag is cleared.
- Counters remain independent: any number may increment in the same cycle, including several counters selecting the same event.
- freeze and global_en gate only increments. Writes and reads are always serviced.

Optional Feature:
- Macro: PERF_CNT_SHADOW_EN.
- Defined:
  - Each counter has a CNT_WIDTH shadow register, reset to 0.
  - A snap pulse copies all live counters into their shadows at the edge, capturing pre-increment values.
  - Value reads (rd_sel=0) return the shadow; value writes update both live and shadow.
  - This gives coherent multi-counter sampling.
- Undefined: snap is ignored, no shadow storage exists, and value reads return the live counter.

Test Plan:
- Reset and count: rst low mid-count with cnt0=5. Then outputs are all 0, and after release, reads of cnt0 and ctrl0 return 0 with rd_valid one cycle after rd_en.
- Event select: ctrl1 = evt 3, en=1; global_en=1; pulse evt_i[3] 10 times and evt_i[2] 7 times. cnt1 reads 10.
- Wrap and interrupt:
  - Setup: CNT_WIDTH=8, cnt2 written 0xFE, ctrl2 en=1, irq_en=1; 2 events.
  - cnt2 = 0x00, ovf[2]=1, irq=1 one cycle later.
  - A W1C control write then makes ovf[2]=0 and irq=0 the next cycle.
- Priority: value write of 0x100 to cnt0 in the same cycle as an event gives cnt0=0x100. A W1C in the same cycle as a wrap leaves ovf=1.
- Gating and range: freeze=1 during 4 events gives no change. With NUM_CNT=8, a write to idx 9 is ignored and a read of idx 9 returns 0.
- Shadow (PERF_CNT_SHADOW_EN): with cnt0=20, snap, then 5 events: value read returns 20. Snap again: read returns 25.
